// File: rtl/cache_16_ctrl_if.sv
// Step-4 request/control bundle between the pipeline (master) and the
// cache sequencing controller (slave).
interface cache_16_ctrl_if;
  // Handshake: req_valid with req_write/tag/index/offset forms a request that
  // the master holds stable while stall=1; stall is the inverse of ready, and
  // the access completes in the cycle done=1 (stall is 0 in that cycle).
  logic        req_valid;
  logic        req_write;
  logic        tag;
  logic [1:0]  index;
  logic [1:0]  offset;
  logic        hit;

  logic        stall;
  logic        done;
  logic        is_write_mem;
  logic [3:0]  is_load_bus;
  logic        control_tag;
  logic [1:0]  control_index;
  logic [3:0]  control_offset;
  logic [15:0] control_data_mux;
  logic        line_commit;

  modport master (
    output req_valid, req_write, tag, index, offset, hit,
    input  stall, done, is_write_mem, is_load_bus, control_tag,
           control_index, control_offset, control_data_mux, line_commit
  );

  modport slave (
    input  req_valid, req_write, tag, index, offset, hit,
    output stall, done, is_write_mem, is_load_bus, control_tag,
           control_index, control_offset, control_data_mux, line_commit
  );
endinterface

// File: rtl/cache_16_ctrl.sv
// Sequencing controller for the 16-word direct-mapped, write-through,
// read-allocate / write-no-allocate data cache of pipeline step 4.
module cache_16_ctrl #(
  parameter int CACHE_SIZE = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic            clk,
  input  logic            rst,
  cache_16_ctrl_if.slave  bus,
  output logic [1:0]      state_o
);

  localparam int LINES = CACHE_SIZE / LINE_WORDS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    HIT_CHK = 2'd2,
    STORE   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       tag_q, tag_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] off_q, off_d;
  logic       hit_q, hit_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tag_q   <= 1'b0;
      idx_q   <= '0;
      off_q   <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      hit_q   <= hit_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    cnt_d                = cnt_q;
    tag_d                = tag_q;
    idx_d                = idx_q;
    off_d                = off_q;
    hit_d                = hit_q;
    bus.stall            = 1'b0;
    bus.done             = 1'b0;
    bus.is_write_mem     = 1'b0;
    bus.is_load_bus      = '0;
    bus.control_tag      = 1'b0;
    bus.control_index    = '0;
    bus.control_offset   = '0;
    bus.control_data_mux = '0;
    bus.line_commit      = 1'b0;

    // Outputs are held at zero for the whole time reset is asserted, even
    // though the IDLE read-hit path is otherwise purely combinational.
    if (rst) begin
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            if (!bus.req_write && bus.hit) begin
              bus.done = 1'b1;
            end else begin
              bus.stall = 1'b1;
              tag_d     = bus.tag;
              idx_d     = bus.index;
              off_d     = bus.offset;
              hit_d     = bus.hit;
              cnt_d     = '0;
              state_d   = bus.req_write ? STORE : FILL;
            end
          end
        end
        FILL: begin
          bus.stall          = 1'b1;
          bus.is_load_bus    = LINES'(1) << idx_q;
          bus.control_index  = idx_q;
          bus.control_tag    = tag_q;
          bus.control_offset = LINE_WORDS'(1) << cnt_q;
          cnt_d              = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            bus.line_commit = 1'b1;
            state_d         = HIT_CHK;
          end
        end
        HIT_CHK: begin
          // A miss here means the tag/valid write did not land; done stays low.
          bus.done = bus.hit;
          state_d  = IDLE;
        end
        STORE: begin
          bus.is_write_mem = 1'b1;
          bus.done         = 1'b1;
          if (hit_q) begin
            bus.is_load_bus      = LINES'(1) << idx_q;
            bus.control_index    = idx_q;
            bus.control_offset   = LINE_WORDS'(1) << off_q;
            bus.control_data_mux = CACHE_SIZE'(1) << {idx_q, off_q};
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign state_o = state_q;

  hit_chk_a: assert property (@(posedge clk) disable iff (!rst)
    (state_q == HIT_CHK) |-> bus.hit);

endmodule

// File: tb/tb_cache_16_ctrl.sv
// Vector table plus scoreboard bench for cache_16_ctrl: each cycle's expected
// output word is queued when the inputs are driven and compared mid-cycle.
module tb_cache_16_ctrl;

  localparam int W = 33;

  typedef struct {
    string      name;
    logic       rst;
    logic       rv;
    logic       rw;
    logic       tag;
    logic [1:0] idx;
    logic [1:0] off;
    logic       hit;
    logic [W-1:0] exp;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] state;

  cache_16_ctrl_if bus ();

  cache_16_ctrl dut (
    .clk     (clk),
    .rst     (rst_n),
    .bus     (bus),
    .state_o (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [W-1:0] exp_q[$];
  vec_t         vecs[$];
  int           errors = 0;
  int           checks = 0;

  // Packing order: state, stall, done, is_write_mem, is_load_bus, control_tag,
  // control_index, control_offset, control_data_mux, line_commit.
  function automatic logic [W-1:0] ex(logic [1:0] st, logic stall, logic done,
                                      logic wm, logic [3:0] lb, logic ct,
                                      logic [1:0] ci, logic [3:0] co,
                                      logic [15:0] dm, logic lc);
    return {st, stall, done, wm, lb, ct, ci, co, dm, lc};
  endfunction

  function automatic logic [W-1:0] observed();
    return {state, bus.stall, bus.done, bus.is_write_mem, bus.is_load_bus,
            bus.control_tag, bus.control_index, bus.control_offset,
            bus.control_data_mux, bus.line_commit};
  endfunction

  function automatic vec_t mk(string name, logic r, logic rv, logic rw, logic t,
                              logic [1:0] i, logic [1:0] o, logic h,
                              logic [W-1:0] e);
    vec_t v;
    v.name = name; v.rst = r; v.rv = rv; v.rw = rw; v.tag = t;
    v.idx = i; v.off = o; v.hit = h; v.exp = e;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    rst_n         = v.rst;
    bus.req_valid = v.rv;
    bus.req_write = v.rw;
    bus.tag       = v.tag;
    bus.index     = v.idx;
    bus.offset    = v.off;
    bus.hit       = v.hit;
    exp_q.push_back(v.exp);
  endtask

  task automatic check(input string name);
    logic [W-1:0] got;
    logic [W-1:0] want;
    got = observed();
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got %h", name, got);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        errors++;
        $display("FAIL %s: got %h expected %h", name, got, want);
      end
    end
  endtask

  task automatic cycle(input vec_t v);
    @(posedge clk);
    #1;
    apply(v);
    @(negedge clk);
    check(v.name);
  endtask

  logic [W-1:0] z;
  logic [3:0]   oh;

  initial begin
    z = ex(2'd0, 0, 0, 0, 4'h0, 0, 2'd0, 4'h0, 16'h0, 0);
    rst_n = 1'b0;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.tag = 1'b0;
    bus.index = 2'd0; bus.offset = 2'd0; bus.hit = 1'b1;

    // Reset held with a request present, then a read hit right after release.
    for (int i = 0; i < 3; i++) vecs.push_back(mk("rst_hold", 0, 1, 0, 0, 2'd0, 2'd0, 1, z));
    vecs.push_back(mk("rd_hit_after_rst", 1, 1, 0, 0, 2'd0, 2'd0, 1,
                      ex(2'd0, 0, 1, 0, 4'h0, 0, 2'd0, 4'h0, 16'h0, 0)));
    vecs.push_back(mk("idle_no_req", 1, 0, 0, 0, 2'd0, 2'd0, 0, z));

    // Read miss at 0x16; address noise during FILL must be ignored.
    vecs.push_back(mk("miss16_req", 1, 1, 0, 1, 2'd1, 2'd2, 0,
                      ex(2'd0, 1, 0, 0, 4'h0, 0, 2'd0, 4'h0, 16'h0, 0)));
    for (int k = 0; k < 4; k++) begin
      oh = 4'b0001 << k;
      vecs.push_back(mk("miss16_fill", 1, 1, 0, 0, 2'd3, 2'd0, 0,
                        ex(2'd1, 1, 0, 0, 4'b0010, 1, 2'd1, oh, 16'h0, k == 3)));
    end
    vecs.push_back(mk("miss16_hitchk", 1, 1, 0, 1, 2'd1, 2'd2, 1,
                      ex(2'd2, 0, 1, 0, 4'h0, 0, 2'd0, 4'h0, 16'h0, 0)));

    // Store hit at 0x0B, then store miss at 0x1F.
    vecs.push_back(mk("st0b_req", 1, 1, 1, 0, 2'd2, 2'd3, 1,
                      ex(2'd0, 1, 0, 0, 4'h0, 0, 2'd0, 4'h0, 16'h0, 0)));
    vecs.push_back(mk("st0b_store", 1, 1, 1, 0, 2'd0, 2'd0, 0,
                      ex(2'd3, 0, 1, 1, 4'b0100, 0, 2'd2, 4'b1000, 16'h0800, 0)));
    vecs.push_back(mk("st1f_req", 1, 1, 1, 1, 2'd3, 2'd3, 0,
                      ex(2'd0, 1, 0, 0, 4'h0, 0, 2'd0, 4'h0, 16'h0, 0)));
    vecs.push_back(mk("st1f_store", 1, 1, 1, 0, 2'd0, 2'd0, 1,
                      ex(2'd3, 0, 1, 1, 4'h0, 0, 2'd0, 4'h0, 16'h0, 0)));

    // Back-to-back: read miss idx3, store hit idx0/off1, read hit, held valid.
    vecs.push_back(mk("b2b_miss_req", 1, 1, 0, 0, 2'd3, 2'd1, 0,
                      ex(2'd0, 1, 0, 0, 4'h0, 0, 2'd0, 4'h0, 16'h0, 0)));
    for (int k = 0; k < 4; k++) begin
      oh = 4'b0001 << k;
      vecs.push_back(mk("b2b_fill", 1, 1, 0, 1, 2'd0, 2'(k), 0,
                        ex(2'd1, 1, 0, 0, 4'b1000, 0, 2'd3, oh, 16'h0, k == 3)));
    end
    vecs.push_back(mk("b2b_hitchk", 1, 1, 0, 0, 2'd3, 2'd1, 1,
                      ex(2'd2, 0, 1, 0, 4'h0, 0, 2'd0, 4'h0, 16'h0, 0)));
    vecs.push_back(mk("b2b_st_req", 1, 1, 1, 0, 2'd0, 2'd1, 1,
                      ex(2'd0, 1, 0, 0, 4'h0, 0, 2'd0, 4'h0, 16'h0, 0)));
    vecs.push_back(mk("b2b_st_store", 1, 1, 1, 0, 2'd0, 2'd1, 1,
                      ex(2'd3, 0, 1, 1, 4'b0001, 0, 2'd0, 4'b0010, 16'h0002, 0)));
    vecs.push_back(mk("b2b_rd_hit", 1, 1, 0, 0, 2'd3, 2'd1, 1,
                      ex(2'd0, 0, 1, 0, 4'h0, 0, 2'd0, 4'h0, 16'h0, 0)));
    vecs.push_back(mk("b2b_idle", 1, 0, 0, 0, 2'd0, 2'd0, 0, z));

    foreach (vecs[i]) cycle(vecs[i]);

    // Reset asserted mid-FILL (cnt=2): outputs drop at once, no line_commit,
    // and the retried request refills from word 0.
    cycle(mk("mf_req", 1, 1, 0, 1, 2'd2, 2'd0, 0,
             ex(2'd0, 1, 0, 0, 4'h0, 0, 2'd0, 4'h0, 16'h0, 0)));
    for (int k = 0; k < 3; k++) begin
      oh = 4'b0001 << k;
      cycle(mk("mf_fill", 1, 1, 0, 1, 2'd2, 2'd0, 0,
               ex(2'd1, 1, 0, 0, 4'b0100, 1, 2'd2, oh, 16'h0, 0)));
    end
    #2;
    rst_n = 1'b0;
    exp_q.push_back(z);
    #1;
    check("mf_async_rst");
    cycle(mk("mf_rst_hold", 0, 1, 0, 1, 2'd2, 2'd0, 0, z));
    cycle(mk("mf_retry_req", 1, 1, 0, 1, 2'd2, 2'd0, 0,
             ex(2'd0, 1, 0, 0, 4'h0, 0, 2'd0, 4'h0, 16'h0, 0)));
    for (int k = 0; k < 4; k++) begin
      oh = 4'b0001 << k;
      cycle(mk("mf_retry_fill", 1, 1, 0, 1, 2'd2, 2'd0, 0,
               ex(2'd1, 1, 0, 0, 4'b0100, 1, 2'd2, oh, 16'h0, k == 3)));
    end
    cycle(mk("mf_retry_hitchk", 1, 1, 0, 1, 2'd2, 2'd0, 1,
             ex(2'd2, 0, 1, 0, 4'h0, 0, 2'd0, 4'h0, 16'h0, 0)));
    cycle(mk("mf_idle", 1, 0, 0, 0, 2'd0, 2'd0, 0, z));

    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
